filter_ewma_hpf_mv: RTL and testbench
=====================================

Name: filter_ewma_hpf_mv

Overview:
- Multi-voice, time-multiplexed EWMA high-pass (DC-blocking) filter.
- It is the complementary output to the synth's EWMA low-pass: it keeps a per-voice low-pass state and emits din minus the updated low-pass.
- It uses one serial shift-add multiplier shared across voices, with a valid/ready input handshake.
- It sits between voice mixers and the output DAC path, and strips DC and low-frequency content per voice.

Parameters:
- DATA_BITS, 12, sample width (signed two's complement).
- VOICES, 4, number of independent filter states; must be ≥2.
- VB, $clog2(VOICES), voice index width (localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_alpha  in  9 signed  cutoff coefficient (−256..255, scale 1/256); sampled on accept.
- din_valid  in  1  input sample valid.
- din_ready  out  1  block can accept a sample.
- din  in  DATA_BITS signed  unfiltered sample.
- din_voice  in  VB  voice index of din.
- dout_valid  out  1  single-cycle strobe; dout and dout_voice are valid.
- dout  out  DATA_BITS signed  high-pass output.
- dout_voice  out  VB  voice index of dout.

Behaviour:
- States:
  - CLEAR: lp[i]<=0, one voice per cycle, VOICES cycles → IDLE.
  - IDLE: din_ready=1. On din_valid, latch din, voice and alpha → DIFF.
  - DIFF: diff = din − lp[v], DATA_BITS+1 bits, no overflow → MUL.
  - MUL: 9 shift-add iterations over |alpha|[8:0]. Signed product = ±(diff·|alpha|), negated if alpha<0 → UPDATE.
  - UPDATE: step = product >>> 8 (arithmetic, floor toward −inf), truncated to DATA_BITS+1. lp_new = lp[v] + step, wrapped to DATA_BITS; lp[v]<=lp_new. hp = din − lp_new, wrapped to DATA_BITS → OUT.
  - OUT: dout, dout_voice registered; dout_valid=1 for exactly one cycle → IDLE.
- Latency: accept edge at cycle 0 gives dout_valid high in cycle 12. Throughput is one sample per 13 cycles.
- din_ready is high only in IDLE. din is ignored when din_ready=0, and a held din_valid is not double-accepted.
- Reset values:
  - dout=0, dout_voice=0, dout_valid=0, din_ready=0.
  - Enters CLEAR; first din_ready=1 arrives VOICES+1 cycles after rst deassert.
- rst mid-operation: the in-flight sample is discarded, no dout_valid is produced, and all lp state is re-cleared.
- din_voice ≥ VOICES: the sample is accepted, dout_valid is still produced, lp is untouched and dout=din.
- alpha=0: lp unchanged, dout = din − lp[v]. alpha=−256 is legal.
- s_alpha changes mid-operation have no effect on the in-flight sample.

Optional Feature:
- FILTER_EWMA_HPF_SAT_EN, defined: lp_new and hp saturate to [−2^(DATA_BITS−1), 2^(DATA_BITS−1)−1] instead of wrapping.
- Undefined: two's-complement wrap as above. Latency is identical in both builds.

Decomposition:
- Shared header (include-guarded) holds:
  - state encoding localparams (CLEAR, IDLE, DIFF, MUL, UPDATE, OUT);
  - ALPHA_BITS=9, ALPHA_SHIFT=8, MUL_ITERS=9;
  - sat/wrap helper macros.
- One sub-module: serial_mul_shift_add. It takes a start pulse, signed (DATA_BITS+1)-bit multiplicand and 9-bit signed multiplier, and returns a done pulse after 9 cycles with the full signed product.

Test Plan (DATA_BITS=12):
- Reset/clear: pulse rst with lp previously nonzero → din_ready low for 5 cycles after deassert (VOICES=4). Then alpha=0, din=300 on each voice → dout=300.
- Convergence: voice 0, alpha=128, din=1000 twice → dout=500 then 250, each 12 cycles after its accept.
- Voice isolation: alpha=128. Voice 1 din=1000, voice 2 din=−400, voice 1 din=1000 → dout 500, −200, 250 with matching dout_voice.
- Floor rounding: alpha=1, voice 3 from 0: din=1 → dout=1 (lp stays 0); din=−1 → dout=0 (lp becomes −1).
- Overflow: alpha=−256, lp=0, din=1500.
  - Wrap build: lp=−1500, dout=−1096.
  - With FILTER_EWMA_HPF_SAT_EN: dout=2047.
- Handshake/abort: hold din_valid high for 30 cycles → exactly 3 accepts, 13 cycles apart. Assert rst in the MUL state → no dout_valid for that sample.

Source files
------------

// File: rtl/filter_ewma_hpf_mv_pkg.sv
// filter_ewma_hpf_mv_pkg -- constants shared by the EWMA high-pass filter
// and its serial multiplier.
//
// Contents:
//   ST_*        main controller state encoding
//   ALPHA_BITS  width of the signed cutoff coefficient (scale 1/256)
//   ALPHA_SHIFT fixed-point shift applied to the coefficient product
//   MUL_ITERS   number of shift-add steps in the serial multiplier
package filter_ewma_hpf_mv_pkg;

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_DIFF   = 3'd2;
    localparam logic [2:0] ST_MUL    = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;

    localparam int ALPHA_BITS  = 9;
    localparam int ALPHA_SHIFT = 8;
    localparam int MUL_ITERS   = 9;

endpackage

// File: rtl/filter_ewma_hpf_mv_serial_mul_shift_add.sv
// serial_mul_shift_add -- signed multiplier, one partial product per cycle.
// The multiplier is split into sign and magnitude; the magnitude is walked
// LSB first, and the sign is applied to the accumulated sum on the last step.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   start_i   load operands (performs the first shift-add step as well)
//   mcand_i   signed multiplicand, MCAND_BITS wide
//   mplier_i  signed multiplier, ALPHA_BITS wide (-256..255)
//   done_o    one-cycle strobe, MUL_ITERS cycles after start_i
//   prod_o    full signed product, valid while done_o is high and held after
module serial_mul_shift_add
    import filter_ewma_hpf_mv_pkg::*;
#(
    parameter int MCAND_BITS = 13,
    parameter int PROD_BITS  = MCAND_BITS + ALPHA_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic signed [MCAND_BITS-1:0] mcand_i,
    input  logic signed [ALPHA_BITS-1:0] mplier_i,
    output logic                         done_o,
    output logic signed [PROD_BITS-1:0]  prod_o
);

    localparam int CW = $clog2(MUL_ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITERS - 1);

    logic [ALPHA_BITS-1:0]        mag;
    logic signed [PROD_BITS-1:0]  mcand_ext;
    logic signed [PROD_BITS-1:0]  sum;

    logic signed [PROD_BITS-1:0]  acc_q;
    logic signed [PROD_BITS-1:0]  mcand_q;
    logic [ALPHA_BITS-1:0]        mag_q;
    logic                         neg_q;
    logic [CW-1:0]                cnt_q;
    logic                         busy_q;
    logic                         done_q;
    logic signed [PROD_BITS-1:0]  prod_q;

    // |-256| is 256, which still fits the 9-bit unsigned magnitude.
    assign mag       = mplier_i[ALPHA_BITS-1] ? (~mplier_i + 1'b1) : mplier_i;
    assign mcand_ext = {{(PROD_BITS-MCAND_BITS){mcand_i[MCAND_BITS-1]}}, mcand_i};
    assign sum       = acc_q + (mag_q[0] ? mcand_q : '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                // Bit 0 is consumed on the load edge, bits 1..8 on the next eight.
                acc_q   <= mag[0] ? mcand_ext : '0;
                mcand_q <= mcand_ext << 1;
                mag_q   <= mag >> 1;
                neg_q   <= mplier_i[ALPHA_BITS-1];
                cnt_q   <= CW'(1);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q == CNT_LAST) begin
                    prod_q <= neg_q ? -sum : sum;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end else begin
                    acc_q   <= sum;
                    mcand_q <= mcand_q << 1;
                    mag_q   <= mag_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = prod_q;

endmodule

// File: rtl/filter_ewma_hpf_mv.sv
// filter_ewma_hpf_mv -- time-multiplexed multi-voice EWMA high-pass filter.
// Keeps one low-pass state per voice, lp += (din - lp) * alpha / 256, and
// emits din - lp_new. One sample is processed at a time through a shared
// serial multiplier; a new sample is accepted every 13 cycles.
//
// Build option: define FILTER_EWMA_HPF_SAT_EN to saturate lp_new and the
// output to the DATA_BITS signed range instead of wrapping. Timing is
// identical in both builds.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (re-clears all voices)
//   s_alpha     signed cutoff coefficient, sampled when a sample is accepted
//   din_valid   input sample valid
//   din_ready   high only while idle; a sample is taken when both are high
//   din         signed input sample
//   din_voice   voice index of din (indices >= VOICES pass din through)
//   dout_valid  one-cycle strobe qualifying dout/dout_voice
//   dout        signed high-pass output
//   dout_voice  voice index of dout
module filter_ewma_hpf_mv
    import filter_ewma_hpf_mv_pkg::*;
#(
    parameter  int DATA_BITS = 12,
    parameter  int VOICES    = 4,
    localparam int VB        = $clog2(VOICES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [ALPHA_BITS-1:0] s_alpha,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic signed [DATA_BITS-1:0]  din,
    input  logic [VB-1:0]                din_voice,
    output logic                         dout_valid,
    output logic signed [DATA_BITS-1:0]  dout,
    output logic [VB-1:0]                dout_voice
);

    localparam int DW1 = DATA_BITS + 1;
    localparam int DW2 = DATA_BITS + 2;
    localparam int PW  = DW1 + ALPHA_BITS;
    localparam logic [VB:0] CLR_LAST = (VB+1)'(VOICES);

    // Fit a DW2-bit intermediate into DATA_BITS.
    function automatic logic signed [DATA_BITS-1:0] fit(input logic signed [DW2-1:0] x);
`ifdef FILTER_EWMA_HPF_SAT_EN
        logic signed [DW2-1:0] hi;
        logic signed [DW2-1:0] lo;
        hi = DW2'((2 ** (DATA_BITS - 1)) - 1);
        lo = DW2'(-(2 ** (DATA_BITS - 1)));
        if (x > hi)      return hi[DATA_BITS-1:0];
        else if (x < lo) return lo[DATA_BITS-1:0];
        else             return x[DATA_BITS-1:0];
`else
        return DATA_BITS'(x);
`endif
    endfunction

    logic [2:0]                   state_q, state_d;
    logic [VB:0]                  clr_q;
    logic signed [DATA_BITS-1:0]  din_q;
    logic [VB-1:0]                voice_q;
    logic signed [ALPHA_BITS-1:0] alpha_q;
    logic signed [DATA_BITS-1:0]  lp_q [VOICES];
    logic signed [DATA_BITS-1:0]  dout_q;
    logic [VB-1:0]                dout_voice_q;
    logic                         dout_valid_q;

    logic                         voice_ok;
    logic signed [DATA_BITS-1:0]  lp_cur;
    logic signed [DW1-1:0]        diff;
    logic                         mul_done;
    logic signed [PW-1:0]         prod;
    logic signed [DW1-1:0]        step;
    logic signed [DW2-1:0]        lp_sum;
    logic signed [DATA_BITS-1:0]  lp_new;
    logic signed [DW2-1:0]        hp_full;
    logic signed [DATA_BITS-1:0]  hp;

    // Out-of-range voices only exist when VOICES is not a power of two.
    generate
        if (VOICES == (1 << VB)) begin : g_full_range
            assign voice_ok = 1'b1;
        end else begin : g_partial_range
            assign voice_ok = (voice_q < VB'(VOICES));
        end
    endgenerate

    assign lp_cur = voice_ok ? lp_q[voice_q] : '0;
    assign diff   = {din_q[DATA_BITS-1], din_q} - {lp_cur[DATA_BITS-1], lp_cur};

    serial_mul_shift_add #(
        .MCAND_BITS (DW1),
        .PROD_BITS  (PW)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (state_q == ST_DIFF),
        .mcand_i  (diff),
        .mplier_i (alpha_q),
        .done_o   (mul_done),
        .prod_o   (prod)
    );

    // Arithmetic shift floors toward -inf, so tiny negative steps become -1.
    assign step    = DW1'(prod >>> ALPHA_SHIFT);
    assign lp_sum  = {{2{lp_cur[DATA_BITS-1]}}, lp_cur} + {step[DW1-1], step};
    assign lp_new  = fit(lp_sum);
    assign hp_full = {{2{din_q[DATA_BITS-1]}}, din_q} - {{2{lp_new[DATA_BITS-1]}}, lp_new};
    assign hp      = voice_ok ? fit(hp_full) : din_q;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR:  if (clr_q == CLR_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (din_valid) state_d = ST_DIFF;
            ST_DIFF:   state_d = ST_MUL;
            ST_MUL:    if (mul_done) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_OUT;
            ST_OUT:    state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_q        <= '0;
            din_q        <= '0;
            voice_q      <= '0;
            alpha_q      <= '0;
            dout_q       <= '0;
            dout_voice_q <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dout_valid_q <= 1'b0;
            // CLEAR runs one extra cycle past the last voice before going idle.
            if (state_q == ST_CLEAR && clr_q != CLR_LAST) clr_q <= clr_q + 1'b1;
            if (state_q == ST_IDLE && din_valid) begin
                din_q   <= din;
                voice_q <= din_voice;
                alpha_q <= s_alpha;
            end
            if (state_q == ST_UPDATE) begin
                dout_q       <= hp;
                dout_voice_q <= voice_q;
                dout_valid_q <= 1'b1;
            end
        end
    end

    // NOTE: the per-voice state is a memory with no reset branch; it is wiped
    // by the CLEAR walk, one entry per cycle, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR && clr_q != CLR_LAST) begin
                lp_q[clr_q[VB-1:0]] <= '0;
            end else if (state_q == ST_UPDATE && voice_ok) begin
                lp_q[voice_q] <= lp_new;
            end
        end
    end

    assign din_ready  = (state_q == ST_IDLE);
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_voice = dout_voice_q;

endmodule

// File: tb/tb_filter_ewma_hpf_mv.sv
// tb_filter_ewma_hpf_mv -- self-checking bench for filter_ewma_hpf_mv
// (DATA_BITS=12, VOICES=4). Expected outputs come from an integer model of
// the EWMA recurrence kept in model_lp[].
module tb_filter_ewma_hpf_mv;

    localparam int DATA_BITS = 12;
    localparam int VOICES    = 4;
    localparam int VB        = 2;
    localparam int LATENCY   = 12;
    localparam int PERIOD    = 13;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic signed [8:0]           s_alpha = '0;
    logic                        din_valid = 1'b0;
    logic                        din_ready;
    logic signed [DATA_BITS-1:0] din = '0;
    logic [VB-1:0]               din_voice = '0;
    logic                        dout_valid;
    logic signed [DATA_BITS-1:0] dout;
    logic [VB-1:0]               dout_voice;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int model_lp [VOICES];

    filter_ewma_hpf_mv #(.DATA_BITS(DATA_BITS), .VOICES(VOICES)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_alpha    (s_alpha),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .din_voice  (din_voice),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_voice (dout_voice)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dout_valid === 1'b1) n_pulses++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int model_fit(input int x);
`ifdef FILTER_EWMA_HPF_SAT_EN
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
`else
        return ((x % 4096) + 4096 + 2048) % 4096 - 2048;
`endif
    endfunction

    function automatic int model_floor_div256(input int p);
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    function automatic int model_sample(input int v, input int d, input int a);
        int lp_new;
        lp_new = model_fit(model_lp[v] + model_floor_div256((d - model_lp[v]) * a));
        model_lp[v] = lp_new;
        return model_fit(d - lp_new);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < VOICES; i++) model_lp[i] = 0;
    endfunction

    function automatic int rand_din();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    // ---------------- drivers ----------------
    // Offers one sample and waits for its result. lat counts posedges from
    // the accept edge to the edge at which dout_valid is first seen high.
    task automatic run_sample(input int v, input int d, input int a,
                              output int obs, output int obs_voice,
                              output int lat, output logic after);
        int waited;
        waited = 0;
        obs = 0; obs_voice = -1; lat = -1; after = 1'bx;
        @(negedge clk);
        while (din_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        din_valid = 1'b1;
        din       = DATA_BITS'(d);
        s_alpha   = 9'(a);
        din_voice = VB'(v);
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs after the accept; they must not matter.
                din_valid = 1'b0;
                din       = DATA_BITS'($urandom);
                s_alpha   = 9'($urandom);
                din_voice = VB'($urandom);
            end
            if (dout_valid === 1'b1) begin
                lat       = k;
                obs       = int'(dout);
                obs_voice = int'(dout_voice);
                @(negedge clk);
                after = dout_valid;
                break;
            end
        end
    endtask

    // Called at a negedge with rst high; releases it and counts idle-low cycles.
    task automatic release_reset(output int low_cycles);
        rst = 1'b0;
        low_cycles = 0;
        while (din_ready !== 1'b1 && low_cycles < 50) begin
            low_cycles++;
            @(negedge clk);
        end
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int low;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b, expected 0", dout_valid); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b, expected 0", din_ready); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0d, expected 0", dout); end
        n_checks++; if (dout_voice !== '0) begin n_fail++; $display("FAIL reset_dout_voice: got %0d, expected 0", dout_voice); end
        release_reset(low);
        n_checks++; if (low != VOICES + 1) begin n_fail++; $display("FAIL reset_clear_cycles: got %0d, expected %0d", low, VOICES + 1); end
    endtask

    task automatic test_convergence();
        int obs, ov, lat, exp_m;
        logic after;
        int hp_ref[2] = '{500, 250};
        for (int i = 0; i < 2; i++) begin
            exp_m = model_sample(0, 1000, 128);
            run_sample(0, 1000, 128, obs, ov, lat, after);
            n_checks++; if (obs != hp_ref[i] || obs != exp_m) begin n_fail++; $display("FAIL convergence_dout[%0d]: got %0d, expected %0d", i, obs, hp_ref[i]); end
            n_checks++; if (lat != LATENCY) begin n_fail++; $display("FAIL convergence_latency[%0d]: got %0d, expected %0d", i, lat, LATENCY); end
            n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL convergence_strobe_width[%0d]: got %b, expected 0", i, after); end
        end
    endtask

    task automatic test_voice_isolation();
        int obs, ov, lat;
        logic after;
        int vv[3]  = '{1, 2, 1};
        int dd[3]  = '{1000, -400, 1000};
        int ref_hp[3] = '{500, -200, 250};
        for (int i = 0; i < 3; i++) begin
            void'(model_sample(vv[i], dd[i], 128));
            run_sample(vv[i], dd[i], 128, obs, ov, lat, after);
            n_checks++; if (obs != ref_hp[i]) begin n_fail++; $display("FAIL isolation_dout[%0d]: got %0d, expected %0d", i, obs, ref_hp[i]); end
            n_checks++; if (ov != vv[i]) begin n_fail++; $display("FAIL isolation_voice[%0d]: got %0d, expected %0d", i, ov, vv[i]); end
        end
    endtask

    task automatic test_floor();
        int obs, ov, lat;
        logic after;
        void'(model_sample(3, 1, 1));
        run_sample(3, 1, 1, obs, ov, lat, after);
        n_checks++; if (obs != 1) begin n_fail++; $display("FAIL floor_pos: got %0d, expected 1", obs); end
        void'(model_sample(3, -1, 1));
        run_sample(3, -1, 1, obs, ov, lat, after);
        n_checks++; if (obs != 0) begin n_fail++; $display("FAIL floor_neg: got %0d, expected 0", obs); end
        // alpha=0 exposes lp directly: 0 - (-1) = 1.
        void'(model_sample(3, 0, 0));
        run_sample(3, 0, 0, obs, ov, lat, after);
        n_checks++; if (obs != 1) begin n_fail++; $display("FAIL floor_lp_probe: got %0d, expected 1", obs); end
    endtask

    task automatic test_abort();
        int low, pulses_before, obs, ov, lat;
        logic after;
        @(negedge clk);
        while (din_ready !== 1'b1) @(negedge clk);
        din_valid = 1'b1; din = DATA_BITS'(700); s_alpha = 9'(200); din_voice = 2'd2;
        @(posedge clk);
        pulses_before = n_pulses;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);   // now in the multiply phase
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset: got %b, expected 0", din_ready); end
        release_reset(low);
        n_checks++; if (low != VOICES + 1) begin n_fail++; $display("FAIL abort_clear_cycles: got %0d, expected %0d", low, VOICES + 1); end
        repeat (25) @(negedge clk);
        n_checks++; if (n_pulses != pulses_before) begin n_fail++; $display("FAIL abort_no_output: got %0d pulses, expected 0", n_pulses - pulses_before); end
        for (int v = 0; v < VOICES; v++) begin
            void'(model_sample(v, 300, 0));
            run_sample(v, 300, 0, obs, ov, lat, after);
            n_checks++; if (obs != 300) begin n_fail++; $display("FAIL abort_recleared[v%0d]: got %0d, expected 300", v, obs); end
        end
    endtask

    task automatic test_overflow();
        int obs, ov, lat, exp_hp;
        logic after;
`ifdef FILTER_EWMA_HPF_SAT_EN
        exp_hp = 2047;
`else
        exp_hp = -1096;
`endif
        void'(model_sample(0, 1500, -256));
        run_sample(0, 1500, -256, obs, ov, lat, after);
        n_checks++; if (obs != exp_hp) begin n_fail++; $display("FAIL overflow_dout: got %0d, expected %0d", obs, exp_hp); end
        void'(model_sample(0, 0, 0));
        run_sample(0, 0, 0, obs, ov, lat, after);
        n_checks++; if (obs != 1500) begin n_fail++; $display("FAIL overflow_lp_probe: got %0d, expected 1500", obs); end
    endtask

    task automatic test_back_to_back();
        int accept_at[$];
        int outs[$];
        int exp_q[$];
        int d, a, v, waited;
        d = int'($urandom_range(2000)) - 1000;
        a = int'($urandom_range(255));
        v = int'($urandom_range(VOICES - 1));
        waited = 0;
        @(negedge clk);
        while (din_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
        din_valid = 1'b1; din = DATA_BITS'(d); s_alpha = 9'(a); din_voice = VB'(v);
        for (int c = 0; c < 45; c++) begin
            if (c == 30) din_valid = 1'b0;
            if (dout_valid === 1'b1) outs.push_back(int'(dout));
            if (din_valid && din_ready === 1'b1) begin
                accept_at.push_back(c);
                exp_q.push_back(model_sample(v, d, a));
            end
            @(negedge clk);
        end
        n_checks++; if (accept_at.size() != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d, expected 3", accept_at.size()); end
        for (int i = 1; i < accept_at.size(); i++) begin
            n_checks++; if (accept_at[i] - accept_at[i-1] != PERIOD) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d, expected %0d", i, accept_at[i] - accept_at[i-1], PERIOD); end
        end
        n_checks++; if (outs.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_outputs: got %0d, expected %0d", outs.size(), exp_q.size()); end
        for (int i = 0; i < outs.size() && i < exp_q.size(); i++) begin
            n_checks++; if (outs[i] != exp_q[i]) begin n_fail++; $display("FAIL b2b_dout[%0d]: got %0d, expected %0d", i, outs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int obs, ov, lat, v, d, a, exp_hp;
        logic after;
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(VOICES - 1));
            d = rand_din();
            a = int'($urandom_range(511)) - 256;
            exp_hp = model_sample(v, d, a);
            run_sample(v, d, a, obs, ov, lat, after);
            n_checks++; if (obs != exp_hp) begin n_fail++; $display("FAIL random_dout[%0d]: got %0d, expected %0d (v=%0d din=%0d alpha=%0d)", i, obs, exp_hp, v, d, a); end
            n_checks++; if (ov != v) begin n_fail++; $display("FAIL random_voice[%0d]: got %0d, expected %0d", i, ov, v); end
            n_checks++; if (lat != LATENCY) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d, expected %0d", i, lat, LATENCY); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_convergence();
        test_voice_isolation();
        test_floor();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
